// File: rtl/gate_sweep_ctrl_if.sv
// gate_sweep_ctrl_if
// Bundles the signals exchanged between the sweep sequencer and its
// surroundings (board controls on one side, the gate under test on the other).
//   start     : level request to begin a sweep
//   x         : output of the gate under test
//   a, b      : gate inputs driven by the sequencer
//   busy      : sweep in progress
//   done      : one-cycle completion pulse
//   pass      : last completed sweep had no mismatches
//   fail_mask : per-vector mismatch flags of the last sweep
//   err_cnt   : number of mismatching vectors of the last sweep
// The slave modport is the sequencer; master is whoever drives start/x.
interface gate_sweep_ctrl_if;
  logic       start;
  logic       x;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] err_cnt;

  modport master (
    output start,
    output x,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  err_cnt
  );

  modport slave (
    input  start,
    input  x,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output err_cnt
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Walks a 2-input gate through the vectors {a,b} = 00,10,01,11, holds each
// for SETTLE cycles, samples the gate output and compares it against the
// EXPECT truth table (bit i = expected x for vector i, default XOR).
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : gate_sweep_ctrl_if slave (start/x in, a/b/busy/done/pass/
//           fail_mask/err_cnt out)
// SETTLE must lie in 1..15 so the settle counter fits in 4 bits.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 4,
  parameter logic [3:0]  EXPECT = 4'b0110
) (
  input logic             clk,
  input logic             rst_n,
  gate_sweep_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic [3:0] sample_mask;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_cnt_d   = err_cnt_q;
    sample_mask = mask_q;

    case (state_q)
      IDLE: begin
        // Result registers clear at launch so a stale verdict never
        // coexists with busy.
        if (bus.start) begin
          state_d     = RUN;
          idx_d       = 2'd0;
          cnt_d       = 4'd0;
          mask_d      = 4'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          fail_mask_d = 4'd0;
          err_cnt_d   = 3'd0;
        end
      end
      RUN: begin
        if (cnt_q < SETTLE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d                = 4'd0;
          sample_mask[idx_q]   = (bus.x != EXPECT[idx_q]);
          mask_d               = sample_mask;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            a_d   = idx_d[0];
            b_d   = idx_d[1];
          end else begin
            // The vector-3 result is folded in via sample_mask, not mask_q.
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            a_d         = 1'b0;
            b_d         = 1'b0;
            fail_mask_d = sample_mask;
            err_cnt_d   = popcount4(sample_mask);
            pass_d      = (sample_mask == 4'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      mask_q      <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
      err_cnt_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises a 2-input combinational gate (my_xor and sibling basic-gate modules) in hardware. On `start` it drives the four input vectors in the order {a,b} = 00, 10, 01, 11, waits a programmable settle time per vector, and samples the gate output. It compares each sample against a parameterised truth table and reports a pass flag, a per-vector fail mask and an error count. It sits between board switches/buttons and the gate under test, replacing the hand-written stimulus sequence.

## Interface
- `SETTLE`, 4: cycles each vector is held before sampling; legal range 1..15.
- `EXPECT`, 4'b0110: expected gate output indexed by vector number; bit i is the expected `x` for vector i. The default is XOR.

- `clk` input 1: single system clock; all state on rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `start` input 1: level; sampled only in IDLE; begins a sweep.
- `x` input 1: output of gate under test.
- `a` output 1: gate input a = vector index bit 0.
- `b` output 1: gate input b = vector index bit 1.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: one-cycle pulse when a sweep completes.
- `pass` output 1: high when the last completed sweep had zero mismatches.
- `fail_mask` output 4: bit i set when vector i mismatched in the last sweep.
- `err_cnt` output 3: number of mismatching vectors, 0..4.

## Operation
- FSM states: IDLE, RUN.
  - IDLE -> RUN when `start`=1.
  - RUN -> IDLE after the vector-3 sample.
  - No other transitions.
- Internal registers:
  - `idx[1:0]` holds the vector number.
  - `cnt[3:0]` counts settle cycles.
  - `mask[3:0]` accumulates mismatches during the sweep.
- IDLE -> RUN edge:
  - `idx`←0, `cnt`←0, `mask`←0, `busy`←1, a←0, b←0.
  - `pass`, `fail_mask` and `err_cnt` clear to 0 at this same edge.
- In RUN, on each edge:
  - If `cnt` < SETTLE-1: `cnt`←`cnt`+1.
  - Else sample `x`, set `mask[idx]` ← (`x` != EXPECT[idx]), and `cnt`←0.
  - After the sample, if `idx`<3: `idx`←`idx`+1 and a/b update to the new vector.
  - After the sample, if `idx`=3: go to IDLE with `busy`←0, `done`←1, a←0, b←0.
  - At that final edge: `fail_mask`←final mask (including the vector-3 result), `err_cnt`←popcount(final mask), `pass`←(final mask==0).
- `done` is high for exactly one cycle; otherwise 0.
- `pass`, `fail_mask` and `err_cnt` hold until the next sweep starts or reset.
- `start` while in RUN is ignored. `start` held high continuously re-launches a sweep on the cycle after `done`.
- `x` is treated as synchronous and settled. No synchroniser is included; the settle time covers gate propagation.

## Timing
- Reset (`rst_n`=0 at a rising edge), from any state including mid-sweep:
  - State→IDLE.
  - a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, err_cnt=0.
  - Internal `idx`, `cnt` and `mask` clear to 0.
- Start latency: `start` sampled at edge T0 gives busy=1 and vector 0 on the outputs from T0.
- Vector i is driven from edge T0+i·SETTLE to edge T0+(i+1)·SETTLE.
- `x` is sampled at edges T0+(i+1)·SETTLE.
- Sweep length: exactly 4·SETTLE cycles with busy=1.
- `done`, `pass`, `fail_mask` and `err_cnt` become valid after edge T0+4·SETTLE.
- With SETTLE=1, a vector changes every cycle and `x` is sampled in the same cycle it was driven. This requires a purely combinational gate.
- Earliest restart: `start` sampled at T0+4·SETTLE+1 (the cycle in which `done`=1) launches the next sweep.

## Test plan
- XOR gate, SETTLE=4, start pulse at T0:
  - busy high for 16 cycles.
  - a/b sequence 00,10,01,11, each held 4 cycles.
  - done pulse at T0+16; pass=1, fail_mask=0000, err_cnt=0.
- `x` forced 0 with EXPECT=0110: pass=0, fail_mask=0110, err_cnt=2.
- `x` = XNOR of a,b with EXPECT=0110: fail_mask=1111, err_cnt=4, pass=0.
- AND gate with EXPECT=1000, SETTLE=1: busy for 4 cycles, then pass=1, err_cnt=0.
- Reset mid-sweep:
  - `start`; at T0+6 assert `rst_n`=0 for one edge.
  - Immediately all outputs are 0 and FSM is IDLE.
  - A following `start` completes a full 4·SETTLE-cycle sweep normally.
- Extra `start` pulses at T0+3 and T0+10 (SETTLE=4): ignored, exactly one `done` at T0+16.
- `start` held high: back-to-back sweeps, with `done` every 4·SETTLE+1 cycles.
